// File: rtl/as7_share_arbiter_if.sv
// Request/result bundle between the two requesters and the shared AS7 arbiter.
// i_* are driven by the requesters, o_* are driven back by the arbiter.
interface as7_share_arbiter_if;
   logic       i_req0;
   logic       i_sub0;
   logic [6:0] i_a0;
   logic [6:0] i_b0;
   logic       i_req1;
   logic       i_sub1;
   logic [6:0] i_a1;
   logic [6:0] i_b1;
   logic       o_done0;
   logic       o_done1;
   logic [6:0] o_result;
   logic       o_carry;
   logic       o_ovf;
   logic       o_busy;

   modport slave (
      input  i_req0, i_sub0, i_a0, i_b0,
      input  i_req1, i_sub1, i_a1, i_b1,
      output o_done0, o_done1, o_result,
      output o_carry, o_ovf, o_busy
   );

   modport master (
      output i_req0, i_sub0, i_a0, i_b0,
      output i_req1, i_sub1, i_a1, i_b1,
      input  o_done0, o_done1, o_result,
      input  o_carry, o_ovf, o_busy
   );
endinterface

// File: rtl/as7_share_arbiter.sv
// Round-robin sharing of one 7-bit ripple adder/subtractor (AS7).
// Operands are registered and held for SETTLE_CYCLES before capture.
module as7 (
   input  logic [6:0] i_a,
   input  logic [6:0] i_b,
   input  logic       i_ci,
   output logic [6:0] o_s,
   output logic       o_co
);
   logic [7:0] w_c;
   logic [6:0] w_bx;

   assign w_c[0] = i_ci;
   assign w_bx   = i_b ^ {7{i_ci}};

   // ripple chain: S = A + (B xor Ci) + Ci
   for (genvar k = 0; k < 7; k++) begin : g_fa
      assign o_s[k]   = i_a[k] ^ w_bx[k] ^ w_c[k];
      assign w_c[k+1] = (i_a[k] & w_bx[k]) |
                        (w_c[k] & (i_a[k] ^ w_bx[k]));
   end

   assign o_co = w_c[7];
endmodule

module as7_share_arbiter #(
   parameter int SETTLE_CYCLES = 1
) (
   input logic                i_clk,
   input logic                i_rst,
   as7_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] LP_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t     r_state;
   logic [6:0] r_op_a;
   logic [6:0] r_op_b;
   logic       r_sub;
   logic       r_gid;
   logic [3:0] r_cnt;
   logic       r_last;
   logic       r_won;
   logic [6:0] r_result;
   logic       r_carry;
   logic       r_ovf;
   logic       r_done0;
   logic       r_done1;
   logic       r_busy;

   logic [6:0] w_s;
   logic       w_co;
   logic [6:0] w_beff;
   logic       w_ovf;
   logic       w_pick1;

   as7 u_as7 (
      .i_a  (r_op_a),
      .i_b  (r_op_b),
      .i_ci (r_sub),
      .o_s  (w_s),
      .o_co (w_co)
   );

   assign w_beff = r_op_b ^ {7{r_sub}};
   assign w_ovf  = (r_op_a[6] == w_beff[6]) &&
                   (w_s[6] != r_op_a[6]);

   // requester 1 wins alone, or on contention when 0 won last;
   // before any win has been recorded requester 0 has priority
   assign w_pick1 = bus.i_req1 &
                    (~bus.i_req0 | (r_won & ~r_last));

   // arbitration/sequencing FSM with registered outputs
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= IDLE;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_sub    <= 1'b0;
         r_gid    <= 1'b0;
         r_cnt    <= '0;
         r_last   <= 1'b0;
         r_won    <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_ovf    <= 1'b0;
         r_done0  <= 1'b0;
         r_done1  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (bus.i_req0 | bus.i_req1) begin
                  r_op_a  <= w_pick1 ? bus.i_a1 : bus.i_a0;
                  r_op_b  <= w_pick1 ? bus.i_b1 : bus.i_b0;
                  r_sub   <= w_pick1 ? bus.i_sub1 : bus.i_sub0;
                  r_gid   <= w_pick1;
                  r_cnt   <= LP_LOAD;
                  r_busy  <= 1'b1;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_result <= w_s;
                  r_carry  <= w_co;
                  r_ovf    <= w_ovf;
                  r_last   <= r_gid;
                  r_won    <= 1'b1;
                  r_state  <= DONE;
               end
            end
            DONE: begin
               r_done0 <= ~r_gid;
               r_done1 <= r_gid;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_done0  = r_done0;
   assign bus.o_done1  = r_done1;
   assign bus.o_result = r_result;
   assign bus.o_carry  = r_carry;
   assign bus.o_ovf    = r_ovf;
   assign bus.o_busy   = r_busy;
endmodule
